// File: rtl/vga_pkg.sv
// Shared types and default constants for the VGA front end (button control and
// tile-highlight logic in controlador_vga).
package vga_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RUN} exec_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;  // 10 ms at 25 MHz
  localparam int DEF_GRID_COLS       = 4;
  localparam int DEF_GRID_ROWS       = 4;

  // Counter width that still holds value n-1 when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One button path: 2-flop synchroniser, debouncer and press detector.
// Internally "1" means pressed; the raw line is active-low.
module antirrebote
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_boton_n,
  output logic o_press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;
  logic          w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], ~i_boton_n};
      r_deb_d <= r_deb;
      if (w_sync == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_deb <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Consumer registers this, so its state changes one edge after the flip.
  assign o_press = r_deb & ~r_deb_d;

endmodule

// File: rtl/control_botones.sv
// Button front end: cursor position over the tile grid plus the execute
// request/acknowledge/done handshake toward the processing side.
module control_botones
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int GRID_COLS       = DEF_GRID_COLS,
  parameter int GRID_ROWS       = DEF_GRID_ROWS
) (
  input  logic                                   clock_25,
  input  logic                                   reset,
  input  logic                                   boton_cursor,
  input  logic                                   boton_ejecutar,
  input  logic                                   exec_ack,
  input  logic                                   exec_done,
  output logic [$clog2(GRID_COLS)-1:0]           cursor_x,
  output logic [$clog2(GRID_ROWS)-1:0]           cursor_y,
  output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0] cursor_idx,
  output logic                                   cursor_move,
  output logic                                   exec_req,
  output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0] exec_tile,
  output logic                                   busy
);

  localparam int XW = $clog2(GRID_COLS);
  localparam int YW = $clog2(GRID_ROWS);
  localparam int IW = $clog2(GRID_COLS * GRID_ROWS);

  logic          w_cur_press;
  logic          w_exe_press;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_tile;
  logic          r_move;
  logic          r_req;
  logic          r_busy;
  exec_state_t   r_state;

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cursor (
    .clk       (clock_25),
    .reset     (reset),
    .i_boton_n (boton_cursor),
    .o_press   (w_cur_press)
  );

  antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ejecutar (
    .clk       (clock_25),
    .reset     (reset),
    .i_boton_n (boton_ejecutar),
    .o_press   (w_exe_press)
  );

  always_ff @(posedge clock_25) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_idx   <= '0;
      r_tile  <= '0;
      r_move  <= 1'b0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_move <= 1'b0;
      case (r_state)
        IDLE: begin
          // Execute has priority; a simultaneous cursor press is dropped.
          if (w_exe_press) begin
            r_tile  <= r_idx;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= REQ;
          end else if (w_cur_press) begin
            r_move <= 1'b1;
            if (r_x == XW'(GRID_COLS - 1)) begin
              r_x <= '0;
              if (r_y == YW'(GRID_ROWS - 1)) begin
                r_y <= '0;
              end else begin
                r_y <= r_y + YW'(1);
              end
            end else begin
              r_x <= r_x + XW'(1);
            end
            if (r_idx == IW'(GRID_COLS * GRID_ROWS - 1)) begin
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        REQ: begin
          if (exec_ack) begin
            r_req   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (exec_done) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cursor_x    = r_x;
  assign cursor_y    = r_y;
  assign cursor_idx  = r_idx;
  assign cursor_move = r_move;
  assign exec_req    = r_req;
  assign exec_tile   = r_tile;
  assign busy        = r_busy;

endmodule

// File: doc/control_botones.md
# control_botones

Input conditioning stage in front of the VGA controller. It takes the two raw board push-buttons (cursor and execute), synchronises and debounces them, and converts presses into single-cycle events. It keeps the cursor position over a GRID_COLS × GRID_ROWS tile grid, which the controller uses to highlight the selected image region. It also runs a request/acknowledge/done handshake that tells the processing side to act on the selected tile.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- GRID_COLS, default 4: tiles per row, ≥2.
- GRID_ROWS, default 4: tiles per column, ≥2.

Ports:
- clock_25  in  1  pixel-domain clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- boton_cursor  in  1  raw button, active-low (0 = pressed), asynchronous.
- boton_ejecutar  in  1  raw button, active-low, asynchronous.
- exec_ack  in  1  processing side accepted the request.
- exec_done  in  1  processing side finished; single-cycle pulse.
- cursor_x  out  $clog2(GRID_COLS)  selected column.
- cursor_y  out  $clog2(GRID_ROWS)  selected row.
- cursor_idx  out  $clog2(GRID_COLS*GRID_ROWS)  equals cursor_y*GRID_COLS + cursor_x.
- cursor_move  out  1  one-cycle pulse when the cursor advances.
- exec_req  out  1  request level, held until acknowledged.
- exec_tile  out  same width as cursor_idx  tile index captured at request.
- busy  out  1  high in the REQ and RUN states.

## Operation

- Each button path: a 2-flop synchroniser, then a debouncer, then a press detector.
  - Debouncer keeps a debounced level (reset: released) and a counter.
  - The counter clears whenever the synchronised level equals the debounced level. Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, the debounced level flips and the counter clears.
- Press event: a one-cycle pulse on a debounced released→pressed transition only. Releases produce no event. A held button yields exactly one event.
- Cursor, on a cursor press while in IDLE with no execute press in the same cycle:
  - cursor_x increments.
  - When cursor_x is at GRID_COLS-1, cursor_x wraps to 0 and cursor_y increments.
  - At the last tile, the cursor wraps to (0,0).
  - cursor_move pulses in the same cycle the registers update.
- Execute FSM states:
  - IDLE: an execute press captures cursor_idx into exec_tile and goes to REQ.
  - REQ: exec_req=1 until exec_ack is sampled high, then go to RUN. exec_req drops on the same edge.
  - RUN: on exec_done go to IDLE.
  - exec_done seen in REQ or IDLE is ignored.
- Boundary rules:
  - Cursor presses in REQ or RUN are discarded, not queued. The cursor stays frozen.
  - Execute presses in REQ or RUN are discarded.
  - Cursor and execute events in the same IDLE cycle: execute wins. The cursor does not move, and exec_tile is the pre-press index.
  - exec_ack held high in RUN has no effect.
  - Reset mid-operation returns to IDLE. Debouncers return to released; a button still held at reset release must debounce to pressed and therefore generates one event.

## Timing

- Reset values: cursor_x=0, cursor_y=0, cursor_idx=0, cursor_move=0, exec_req=0, exec_tile=0, busy=0, FSM=IDLE, debounced levels released, counters 0.
- Press latency: edge 1 is the first clock edge sampling the raw line low. The debounced level flips at edge DEBOUNCE_CYCLES+2. The event pulse and the cursor update (or the REQ entry) occur at edge DEBOUNCE_CYCLES+3.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no event.
- REQ→RUN and RUN→IDLE each take one edge after the sampled input. busy is registered and follows the state.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Package vga_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, RUN} exec_state_t.
  - Default grid and debounce constants, shared with controlador_vga for the tile-highlight logic.
- Sub-module antirrebote (synchroniser + debouncer + press pulse, parameter DEBOUNCE_CYCLES). It is instantiated twice.
- Cursor counter and execute FSM live in the top of the block.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and a 4×4 grid.
- Reset: assert reset 3 cycles with buttons released → all outputs 0, busy=0.
- Clean cursor press held 20 cycles → exactly one cursor_move at edge 7; cursor_idx=1. Press 15 more times → cursor_idx=0 with x=0, y=0 (wrap).
- Bouncy press (low 2 cycles, high 1, low 2, high) → no cursor_move. Then a stable low → one event.
- From cursor_idx=5, execute press → exec_req=1, exec_tile=5, busy=1. Cursor presses during REQ/RUN → cursor_idx stays 5. exec_ack at cycle k → exec_req=0 at k+1. exec_done → busy=0 next edge.
- Both buttons pressed in the same cycle at cursor_idx=3 → exec_tile=3, cursor_idx stays 3, no cursor_move.
- Reset asserted in RUN with the execute button held → IDLE, exec_req=0. After reset release, one new request is issued at edge 7 following release.
